dice_roll_engine: RTL and testbench

DICE_ROLL_ENGINE -- requirements
Module: dice_roll_engine

---
 rtl/dice_roll_engine.sv | 168 ++++++++++++++++
 tb/tb_dice_roll_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_engine.sv
// Dice roll engine: draws unbiased die faces from an external entropy source
// using rejection sampling over a bit-serial restoring divider.
module dice_roll_engine #(
    parameter int unsigned RAND_W   = 8,
    parameter int unsigned MAX_DICE = 4,
    parameter int unsigned SIDES_W  = 7,
    localparam int unsigned N_W     = $clog2(MAX_DICE + 1),
    localparam int unsigned SUM_W   = $clog2(MAX_DICE * ((1 << SIDES_W) - 1) + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [SIDES_W-1:0]            sides,
    input  logic [N_W-1:0]                num_dice,
    input  logic [RAND_W-1:0]             rand_value,
    input  logic                          rand_valid,
    output logic                          rand_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [MAX_DICE*SIDES_W-1:0]   die_vals,
    output logic [SUM_W-1:0]              roll_sum,
    output logic [7:0]                    reject_cnt
);

    localparam int unsigned CNT_W = $clog2(RAND_W + 1);
    localparam logic [RAND_W:0] LIMIT = {1'b1, {RAND_W{1'b0}}};

    // The remainder must fit alongside the random word in the acceptance test.
    if (SIDES_W > RAND_W) begin : g_bad_sides_w
        $error("SIDES_W must not exceed RAND_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        DIVIDE,
        CHECK,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [SIDES_W-1:0]   sides_q;
    logic [N_W-1:0]       ndice_q;
    logic [N_W-1:0]       idx;
    logic [RAND_W-1:0]    r_word;
    logic [RAND_W-1:0]    div_sh;
    logic [SIDES_W:0]     rem;
    logic [CNT_W-1:0]     bit_cnt;

    logic                 bad_req_c;
    logic [SIDES_W:0]     rem_sh_c;
    logic [SIDES_W:0]     rem_nx_c;
    logic [RAND_W:0]      chk_c;
    logic                 accept_c;
    logic                 last_c;
    logic [SIDES_W-1:0]   face_c;

    // Request validation, divider step and acceptance test.
    always_comb begin
        bad_req_c = (sides < SIDES_W'(2)) || (num_dice == '0) || (num_dice > N_W'(MAX_DICE));
        rem_sh_c  = {rem[SIDES_W-1:0], div_sh[RAND_W-1]};
        rem_nx_c  = rem_sh_c;
        if (rem_sh_c >= {1'b0, sides_q}) begin
            rem_nx_c = rem_sh_c - {1'b0, sides_q};
        end
        chk_c    = (RAND_W+1)'(r_word) - (RAND_W+1)'(rem) + (RAND_W+1)'(sides_q);
        accept_c = (chk_c <= LIMIT);
        last_c   = ((idx + N_W'(1)) == ndice_q);
        face_c   = SIDES_W'(rem + (SIDES_W+1)'(1));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = bad_req_c ? DONE : SAMPLE;
            SAMPLE:  if (rand_valid) state_nx = DIVIDE;
            DIVIDE:  if (bit_cnt == CNT_W'(RAND_W - 1)) state_nx = CHECK;
            CHECK:   state_nx = (accept_c && last_c) ? DONE : SAMPLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rand_ready <= 1'b0;
        end else begin
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
            rand_ready <= (state_nx == SAMPLE);
        end
    end

    // Roll datapath: request latch, divider, and result accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sides_q    <= '0;
            ndice_q    <= '0;
            idx        <= '0;
            r_word     <= '0;
            div_sh     <= '0;
            rem        <= '0;
            bit_cnt    <= '0;
            err        <= 1'b0;
            die_vals   <= '0;
            roll_sum   <= '0;
            reject_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sides_q    <= sides;
                        ndice_q    <= num_dice;
                        idx        <= '0;
                        err        <= bad_req_c;
                        die_vals   <= '0;
                        roll_sum   <= '0;
                        reject_cnt <= '0;
                    end
                end
                SAMPLE: begin
                    if (rand_valid) begin
                        r_word  <= rand_value;
                        div_sh  <= rand_value;
                        rem     <= '0;
                        bit_cnt <= '0;
                    end
                end
                DIVIDE: begin
                    rem     <= rem_nx_c;
                    div_sh  <= div_sh << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                CHECK: begin
                    if (accept_c) begin
                        for (int i = 0; i < int'(MAX_DICE); i++) begin
                            if (idx == N_W'(i)) begin
                                die_vals[i*SIDES_W +: SIDES_W] <= face_c;
                            end
                        end
                        roll_sum <= roll_sum + SUM_W'(rem) + SUM_W'(1);
                        idx      <= idx + N_W'(1);
                    end else if (reject_cnt != 8'hFF) begin
                        reject_cnt <= reject_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_engine.sv
// Self-checking bench for dice_roll_engine: directed and randomized rolls
// compared against an arithmetic rejection-sampling model.
module tb_dice_roll_engine;

    localparam int unsigned RAND_W   = 8;
    localparam int unsigned MAX_DICE = 4;
    localparam int unsigned SIDES_W  = 7;
    localparam int unsigned N_W      = $clog2(MAX_DICE + 1);
    localparam int unsigned SUM_W    = $clog2(MAX_DICE * ((1 << SIDES_W) - 1) + 1);
    localparam int unsigned VW       = MAX_DICE * SIDES_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [SIDES_W-1:0] sides;
    logic [N_W-1:0]     num_dice;
    logic [RAND_W-1:0]  rand_value;
    logic               rand_valid;
    logic               rand_ready;
    logic               busy;
    logic               done;
    logic               err;
    logic [VW-1:0]      die_vals;
    logic [SUM_W-1:0]   roll_sum;
    logic [7:0]         reject_cnt;

    int checks = 0;
    int errors = 0;
    int wq[$];

    dice_roll_engine #(.RAND_W(RAND_W), .MAX_DICE(MAX_DICE), .SIDES_W(SIDES_W)) dut (
        .clk(clk), .reset(reset), .start(start), .sides(sides), .num_dice(num_dice),
        .rand_value(rand_value), .rand_valid(rand_valid), .rand_ready(rand_ready),
        .busy(busy), .done(done), .err(err), .die_vals(die_vals),
        .roll_sum(roll_sum), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A word is usable when it falls below the largest multiple of s within 2^RAND_W.
    function automatic bit word_ok(input int w, input int s);
        int lim;
        lim = ((2 ** RAND_W) / s) * s;
        return w < lim;
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_err"}, 64'(err), 0);
        chk({tag, "_rdy"}, 64'(rand_ready), 0);
        chk({tag, "_vals"}, 64'(die_vals), 0);
        chk({tag, "_sum"}, 64'(roll_sum), 0);
        chk({tag, "_rej"}, 64'(reject_cnt), 0);
    endtask

    // Run one roll feeding the words in wq, then compare against the model.
    task automatic run_roll(input string tag, input int s, input int n, input bit stall, input bit scramble);
        bit            bad, got, rr_seen;
        int            lat, wi, acc, e_sum, e_rej, e_rej_raw, e_used;
        logic [VW-1:0] e_vals;

        bad = (s < 2) || (n == 0) || (n > int'(MAX_DICE));
        e_vals = '0; e_sum = 0; e_rej = 0; e_rej_raw = 0; acc = 0; e_used = 0;
        if (!bad) begin
            foreach (wq[k]) begin
                if (acc < n) begin
                    e_used = k + 1;
                    if (word_ok(wq[k], s)) begin
                        e_vals = e_vals | (VW'((wq[k] % s) + 1) << (acc * int'(SIDES_W)));
                        e_sum += (wq[k] % s) + 1;
                        acc++;
                    end else begin
                        e_rej_raw++;
                        if (e_rej < 255) e_rej++;
                    end
                end
            end
        end

        sides = SIDES_W'(s);
        num_dice = N_W'(n);
        start = 1'b1;
        rand_valid = 1'b0;
        lat = 0; wi = 0; got = 0; rr_seen = 0;
        while (lat < 5000 && !got) begin
            tick();
            lat++;
            start = scramble ? 1'($urandom) : 1'b0;
            if (scramble) begin
                sides = SIDES_W'($urandom);
                num_dice = N_W'($urandom);
            end
            if (done) begin
                got = 1;
            end else if (rand_ready) begin
                rr_seen = 1;
                if (wi < wq.size() && (!stall || $urandom_range(0, 2) != 0)) begin
                    rand_valid = 1'b1;
                    rand_value = RAND_W'(wq[wi]);
                    wi++;
                end else begin
                    rand_valid = 1'b0;
                    rand_value = RAND_W'($urandom);
                end
            end else begin
                rand_valid = 1'($urandom);
                rand_value = RAND_W'($urandom);
            end
        end
        start = 1'b0;
        rand_valid = 1'b0;

        chk({tag, "_done_seen"}, 64'(got), 1);
        chk({tag, "_err"}, 64'(err), 64'(bad));
        chk({tag, "_vals"}, 64'(die_vals), 64'(e_vals));
        chk({tag, "_sum"}, 64'(roll_sum), 64'(e_sum));
        chk({tag, "_rej"}, 64'(reject_cnt), 64'(e_rej));
        chk({tag, "_used"}, 64'(wi), 64'(e_used));
        if (bad) chk({tag, "_no_rdy"}, 64'(rr_seen), 0);
        if (!stall) chk({tag, "_lat"}, 64'(lat), 64'(1 + (n + e_rej_raw) * int'(RAND_W + 2)) * 64'(!bad) + 64'(bad));

        tick();
        chk({tag, "_pulse_end"}, 64'(done), 0);
        chk({tag, "_idle"}, 64'(busy), 0);
        tick();
        chk({tag, "_hold_vals"}, 64'(die_vals), 64'(e_vals));
        chk({tag, "_hold_sum"}, 64'(roll_sum), 64'(e_sum));
        chk({tag, "_hold_err"}, 64'(err), 64'(bad));
    endtask

    initial begin
        int s, n, a;

        reset = 1'b1; start = 1'b0; sides = '0; num_dice = '0;
        rand_value = '0; rand_valid = 1'b0;
        tick();
        chk_idle_zero("reset");
        reset = 1'b0;
        tick();

        // Single die, accepted top word.
        wq = '{251};
        run_roll("d6x1", 6, 1, 0, 0);
        // One reject between two accepts.
        wq = '{10, 255, 3};
        run_roll("d6x2", 6, 2, 0, 0);
        // All biased top words rejected, then a low word.
        wq = '{252, 253, 254, 255, 0};
        run_roll("d6_top", 6, 1, 0, 0);
        wq = '{251};
        run_roll("d6_251", 6, 1, 0, 0);
        // Invalid requests.
        wq = '{};
        run_roll("bad_s1", 1, 1, 0, 0);
        run_roll("bad_n5", 6, 5, 0, 0);
        run_roll("bad_n0", 6, 0, 0, 0);
        run_roll("bad_s0", 0, 2, 0, 1);
        // Widest die: minimum and maximum faces, plus biased words.
        wq = '{0, 0, 0, 0};
        run_roll("d127_min", 127, 4, 0, 0);
        wq = '{253, 253, 253, 253};
        run_roll("d127_max", 127, 4, 0, 0);
        wq = '{254, 253, 255, 253, 0, 253};
        run_roll("d127_rej", 127, 4, 0, 0);
        // Reject counter saturation.
        wq = '{};
        for (int i = 0; i < 300; i++) wq.push_back(255);
        wq.push_back(0);
        run_roll("sat", 6, 1, 0, 0);

        // Randomized rolls with stalls and mid-roll input changes.
        for (int t = 0; t < 40; t++) begin
            s = $urandom_range(2, 127);
            n = $urandom_range(1, MAX_DICE);
            wq = '{};
            a = 0;
            while (a < n) begin
                int w;
                w = ($urandom_range(0, 3) == 0) ? 255 - $urandom_range(0, 7) : $urandom_range(0, 255);
                wq.push_back(w);
                if (word_ok(w, s)) a++;
            end
            run_roll("rnd", s, n, 1'(t % 2), 1'((t / 2) % 2));
        end

        // Reset during the second die's division, with an ignored start just before.
        sides = 6; num_dice = 2;
        start = 1'b1; rand_valid = 1'b1; rand_value = 10;
        tick();
        start = 1'b0;
        tick();
        rand_value = 3;
        for (int i = 0; i < 12; i++) tick();
        chk("mid_busy", 64'(busy), 1);
        chk("mid_rdy", 64'(rand_ready), 0);
        chk("mid_partial_sum", 64'(roll_sum), 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_start_ignored", 64'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk_idle_zero("async_rst");
        tick();
        reset = 1'b0;
        rand_valid = 1'b0;
        tick();
        tick();
        chk_idle_zero("post_rst");
        wq = '{7, 200, 100};
        run_roll("fresh", 4, 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
